ud_button_conditioner: RTL and testbench

- Upstream stage of the up/down counter: turns two raw push-buttons (up, down) into a clean direction level UD and a one-cycle count-enable pulse step.
- Synchronizes and debounces each button, then arbitrates between them with a small FSM.
- One step per accepted press; UD holds the last accepted direction.
- UD drives the counter's UD input directly; step drives its count enable.

---
 rtl/ud_button_conditioner.sv | 156 +++++++++++++++
 tb/tb_ud_button_conditioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ud_button_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ud_button_conditioner: synchronise and debounce up/down buttons into UD+step.
// Optional macro AUTO_REPEAT_EN enables held-button auto-repeat.  Rev 1.0
// ----------------------------------------------------------------------------
module ud_button_conditioner #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic REST,
  input  logic btn_up,
  input  logic btn_dn,
  output logic UD,
  output logic step,
  output logic busy
);

  localparam int                c_DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CYCLES - 1);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_FIRE_UP = 3'd1;
  localparam logic [2:0] c_ST_FIRE_DN = 3'd2;
  localparam logic [2:0] c_ST_HELD    = 3'd3;
  localparam logic [2:0] c_ST_LOCKOUT = 3'd4;

  // Bit 1 carries the up button, bit 0 the down button throughout.
  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_db;
  logic [1:0] r_db_prev;
  logic [1:0] w_rise;
  logic       w_none_held;

  logic [2:0] r_state;
  logic       r_ud;
  logic       r_step;

  assign w_raw = {btn_up, btn_dn};

  always_ff @(posedge clk or negedge REST) begin
    if (!REST) begin
      r_sync1   <= 2'b00;
      r_sync2   <= 2'b00;
      r_db_prev <= 2'b00;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= w_db;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
    logic [c_DB_W-1:0] r_cnt;
    logic              r_level;

    always_ff @(posedge clk or negedge REST) begin
      if (!REST) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (r_sync2[gi] == r_level) begin
        r_cnt   <= '0;
      end else if (r_cnt == c_DB_LAST) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end

    assign w_db[gi] = r_level;
  end

  assign w_rise      = w_db & ~r_db_prev;
  assign w_none_held = ~|w_db;

`ifdef AUTO_REPEAT_EN
  localparam int                 c_RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [c_RPT_W-1:0] c_RPT_LAST = c_RPT_W'(REPEAT_CYCLES - 1);

  logic [c_RPT_W-1:0] r_rpt;
  logic               w_origin_held;
  logic               w_repeat;

  // UD still names the button that started this hold.
  assign w_origin_held = r_ud ? w_db[1] : w_db[0];
  assign w_repeat      = (r_state == c_ST_HELD) && w_origin_held && !r_step &&
                         (r_rpt == c_RPT_LAST);

  always_ff @(posedge clk or negedge REST) begin
    if (!REST) begin
      r_rpt <= '0;
    end else if ((r_state != c_ST_HELD) || !w_origin_held || w_repeat) begin
      r_rpt <= '0;
    end else if (r_rpt != c_RPT_LAST) begin
      r_rpt <= r_rpt + 1'b1;
    end
  end
`else
  logic w_unused_rpt;
  assign w_unused_rpt = (REPEAT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge REST) begin
    if (!REST) begin
      r_state <= c_ST_IDLE;
      r_ud    <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (&w_rise) begin
            r_state <= c_ST_LOCKOUT;
          end else if (w_rise[1]) begin
            r_state <= c_ST_FIRE_UP;
            r_ud    <= 1'b1;
            r_step  <= 1'b1;
          end else if (w_rise[0]) begin
            r_state <= c_ST_FIRE_DN;
            r_ud    <= 1'b0;
            r_step  <= 1'b1;
          end
        end
        c_ST_FIRE_UP, c_ST_FIRE_DN: begin
          r_state <= c_ST_HELD;
        end
        c_ST_HELD: begin
          if (w_none_held) begin
            r_state <= c_ST_IDLE;
`ifdef AUTO_REPEAT_EN
          end else if (w_repeat) begin
            r_step  <= 1'b1;
`endif
          end
        end
        c_ST_LOCKOUT: begin
          if (w_none_held) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign UD   = r_ud;
  assign step = r_step;
  assign busy = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ud_button_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ud_button_conditioner: table, directed and random checks of the
// button conditioner against a window-based reference model.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_ud_button_conditioner;

  localparam int DB  = 4;
  localparam int RPT = 8;

  logic clk = 1'b0;
  logic REST;
  logic btn_up;
  logic btn_dn;
  logic UD;
  logic step;
  logic busy;

  always #5 clk = ~clk;

  ud_button_conditioner #(.DB_CYCLES(DB), .REPEAT_CYCLES(RPT)) dut (
    .clk    (clk),
    .REST   (REST),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .UD     (UD),
    .step   (step),
    .busy   (busy)
  );

  int n_vec    = 0;
  int n_err    = 0;
  int step_cnt = 0;

  // Reference model: a level changes once the last DB synchronised samples
  // all disagree with it; owner 0 = idle, 1 = up, 2 = down, 3 = both pressed.
  bit   q_up[$];
  bit   q_dn[$];
  logic m_dbu, m_dbd, m_dbu_p, m_dbd_p;
  int   m_owner;
  logic m_fresh;
  logic m_step;
  logic m_ud;
`ifdef AUTO_REPEAT_EN
  int   m_since;
`endif

  task automatic model_reset();
    q_up = {};
    q_dn = {};
    for (int k = 0; k < DB + 2; k++) begin
      q_up.push_back(1'b0);
      q_dn.push_back(1'b0);
    end
    m_dbu = 1'b0; m_dbd = 1'b0; m_dbu_p = 1'b0; m_dbd_p = 1'b0;
    m_owner = 0; m_fresh = 1'b0; m_step = 1'b0; m_ud = 1'b0;
`ifdef AUTO_REPEAT_EN
    m_since = 0;
`endif
  endtask

  task automatic model_edge();
    logic ru, rd, nstep, all_u, all_d;
`ifdef AUTO_REPEAT_EN
    logic held;
`endif
    ru    = m_dbu & ~m_dbu_p;
    rd    = m_dbd & ~m_dbd_p;
    nstep = 1'b0;
    if (m_owner == 0) begin
      if (ru && rd) begin
        m_owner = 3;
      end else if (ru) begin
        m_owner = 1; m_ud = 1'b1; nstep = 1'b1; m_fresh = 1'b1;
      end else if (rd) begin
        m_owner = 2; m_ud = 1'b0; nstep = 1'b1; m_fresh = 1'b1;
      end
    end else if (m_fresh) begin
      m_fresh = 1'b0;
`ifdef AUTO_REPEAT_EN
      m_since = 0;
`endif
    end else if (!m_dbu && !m_dbd) begin
      m_owner = 0;
`ifdef AUTO_REPEAT_EN
    end else if (m_owner != 3) begin
      held = (m_owner == 1) ? m_dbu : m_dbd;
      if (!held) begin
        m_since = 0;
      end else if (m_since == RPT - 1 && !m_step) begin
        nstep = 1'b1; m_since = 0;
      end else if (m_since < RPT - 1) begin
        m_since++;
      end
`endif
    end
    m_step  = nstep;
    m_dbu_p = m_dbu;
    m_dbd_p = m_dbd;
    q_up.push_front(btn_up);
    q_dn.push_front(btn_dn);
    void'(q_up.pop_back());
    void'(q_dn.pop_back());
    all_u = 1'b1;
    all_d = 1'b1;
    for (int k = 0; k < DB; k++) begin
      if (q_up[2 + k] == m_dbu) all_u = 1'b0;
      if (q_dn[2 + k] == m_dbd) all_d = 1'b0;
    end
    if (all_u) m_dbu = ~m_dbu;
    if (all_d) m_dbd = ~m_dbd;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick(input logic up, input logic dn);
    btn_up = up;
    btn_dn = dn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (step === 1'b1) step_cnt++;
  endtask

  typedef struct {
    logic up;
    logic dn;
    int   cycles;
    int   steps;
    int   steps_ar;
    logic ud;
    logic busy;
  } vec_t;

  vec_t tbl[13];
  logic bnc[12];

  initial begin
    int   exp_steps;
    logic got;
    int   run_u, run_d;
    logic lv_u, lv_d;

    tbl[0]  = '{1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1,  8, 1, 1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 10, 0, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 20, 1, 2, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 10, 0, 1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 20, 0, 0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0,  8, 1, 1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1,  8, 0, 1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1,  8, 0, 0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1,  8, 1, 1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 10, 0, 0, 1'b0, 1'b0};
    bnc = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    REST = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
    model_reset();

    // Held in reset while the buttons chatter.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset_outs", {29'd0, UD, step, busy}, 32'd0);
      btn_up = i[0];
      btn_dn = i[1];
    end
    @(negedge clk);
    btn_up = 1'b0; btn_dn = 1'b0; REST = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      if (i % 3 == 0) check("post_reset_outs", {29'd0, UD, step, busy}, 32'd0);
    end

    // Clean press latency: step only after edge DB+2.
    for (int k = 0; k < 13; k++) begin
      tick(1'b1, 1'b0);
      check("press_latency", {29'd0, UD, step, busy},
            {29'd0, (k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0, (k >= 6) ? 1'b1 : 1'b0});
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0);
      check("release_busy", {31'd0, busy}, {31'd0, (k < 6) ? 1'b1 : 1'b0});
    end

    // Table of held levels with step counts and settled levels.
    for (int i = 0; i < 13; i++) begin
      step_cnt = 0;
      for (int c = 0; c < tbl[i].cycles; c++) tick(tbl[i].up, tbl[i].dn);
`ifdef AUTO_REPEAT_EN
      exp_steps = tbl[i].steps_ar;
`else
      exp_steps = tbl[i].steps;
`endif
      check($sformatf("tbl%0d_steps", i), step_cnt, exp_steps);
      check($sformatf("tbl%0d_ud", i), {31'd0, UD}, {31'd0, tbl[i].ud});
      check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
    end

    // Bounce on the down button after an up press.
    for (int c = 0; c < 8; c++) tick(1'b1, 1'b0);
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b0);
    check("pre_bounce_ud", {31'd0, UD}, 32'd1);
    step_cnt = 0;
    for (int k = 0; k < 12; k++) tick(1'b0, bnc[k]);
    check("bounce_no_step", step_cnt, 0);
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b1);
      if (k <= 7) check("bounce_step_time", {31'd0, step}, {31'd0, (k == 6) ? 1'b1 : 1'b0});
      if (k == 6) check("bounce_ud", {31'd0, UD}, 32'd0);
    end
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b0);
    check("bounce_release", {30'd0, UD, busy}, 32'd0);

    // Reset while a step is in flight, then re-debounce the held button.
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick(1'b1, 1'b0);
      if (step === 1'b1) got = 1'b1;
    end
    check("midrst_step_seen", {31'd0, got}, 32'd1);
    REST = 1'b0;
    model_reset();
    #1;
    check("midrst_outs", {29'd0, UD, step, busy}, 32'd0);
    @(negedge clk);
    REST = 1'b1;
    step_cnt = 0;
    for (int c = 0; c < 20; c++) tick(1'b1, 1'b0);
`ifdef AUTO_REPEAT_EN
    check("held_through_reset_steps", step_cnt, 2);
`else
    check("held_through_reset_steps", step_cnt, 1);
`endif
    check("held_through_reset_ud", {31'd0, UD}, 32'd1);
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b0);

    // Random run-length stimulus against the model.
    run_u = 0; run_d = 0; lv_u = 1'b0; lv_d = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (run_u == 0) begin
        lv_u  = 1'($urandom_range(0, 1));
        run_u = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 40)) : int'($urandom_range(1, 8));
      end
      if (run_d == 0) begin
        lv_d  = 1'($urandom_range(0, 1));
        run_d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 40)) : int'($urandom_range(1, 8));
      end
      tick(lv_u, lv_d);
      run_u--;
      run_d--;
      check("random_outs", {29'd0, UD, step, busy},
            {29'd0, m_ud, m_step, (m_owner != 0) ? 1'b1 : 1'b0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
